// File: rtl/mbist_scan_seq_pkg.sv
// Shared definitions for the MBIST scan sequencer: FSM state encoding and
// the width of the error count reported by the MBIST controller.
package mbist_scan_seq_pkg;

    localparam int ERR_CNT_WD = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        STAT  = 3'd4
    } mbist_state_t;

endpackage

// File: rtl/mbist_scan_shreg.sv
// Parallel-load, shift-right scan register. Serial data enters at the MSB and
// leaves from bit 0. A separate capture register snapshots the value the chain
// holds after the current shift, so the last chain word survives a clear.
module mbist_scan_shreg
    import mbist_scan_seq_pkg::*;
#(
    parameter int WD = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load,
    input  logic [WD-1:0] load_data,
    input  logic          shift,
    input  logic          sin,
    input  logic          capture,
    input  logic          cap_clr,
    output logic          sout,
    output logic [WD-1:0] cap_q
);

    logic [WD-1:0] q;
    logic [WD-1:0] shifted;

    // Next value of the chain when one bit is shifted in.
    always_comb begin
        shifted = {sin, q[WD-1:1]};
    end

    // Shift register: clear beats load beats shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= shifted;
        end
    end

    // Snapshot of the chain as it stands after the shift on a capture edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_q <= '0;
        end else if (cap_clr) begin
            cap_q <= '0;
        end else if (capture) begin
            cap_q <= shifted;
        end
    end

    assign sout = q[0];

endmodule

// File: rtl/mbist_scan_seq.sv
// Sequencer that shifts a configuration word into an MBIST scan chain, loads
// it, runs the test with an optional timeout and captures the final status.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for cfg_start, all MBIST controls low
//   SHIFT | shifting SCAN_WD bits LSB first, chain output captured
//   LOAD  | one-cycle bist_load pulse
//   RUN   | bist_run held until bist_done or timeout
//   STAT  | cfg_done pulse, status valid, then back to IDLE
module mbist_scan_seq
    import mbist_scan_seq_pkg::*;
#(
    parameter int SCAN_WD = 32,
    parameter int TMO_WD  = 20
) (
    input  logic                  bist_clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic                  cfg_abort,
    input  logic [SCAN_WD-1:0]    cfg_scan_data,
    input  logic [TMO_WD-1:0]     cfg_tmo,
    output logic                  cfg_busy,
    output logic                  cfg_done,
    output logic                  sts_pass,
    output logic                  sts_fail,
    output logic                  sts_repair,
    output logic                  sts_timeout,
    output logic                  sts_abort,
    output logic [ERR_CNT_WD-1:0] sts_err_cnt,
    output logic [SCAN_WD-1:0]    sts_scan_out,
    output logic                  bist_en,
    output logic                  bist_shift,
    output logic                  bist_load,
    output logic                  bist_run,
    output logic                  bist_sdi,
    input  logic                  bist_done,
    input  logic                  bist_error,
    input  logic                  bist_correct,
    input  logic                  bist_sdo,
    input  logic [ERR_CNT_WD-1:0] bist_error_cnt
);

    localparam int                 BC_WD   = $clog2(SCAN_WD + 1);
    localparam logic [BC_WD-1:0]   BC_LAST = BC_WD'(SCAN_WD - 1);
    localparam logic [TMO_WD-1:0]  TMO_ONE = TMO_WD'(1);

    mbist_state_t      state;
    logic [BC_WD-1:0]  bit_cnt;
    logic [TMO_WD-1:0] tmo_cnt;

    logic abort_hit;
    logic start_hit;
    logic shift_last;

    // Qualified requests and the last-bit marker that drive the FSM and shreg.
    always_comb begin
        abort_hit  = cfg_abort && (state != IDLE);
        start_hit  = cfg_start && (state == IDLE);
        shift_last = (state == SHIFT) && (bit_cnt == BC_LAST);
    end

    // The chain is zeroed after the last bit or an abort so bist_sdi idles low.
    mbist_scan_shreg #(
        .WD (SCAN_WD)
    ) u_shreg (
        .clk       (bist_clk),
        .rst_n     (rst_n),
        .clr       (abort_hit || shift_last),
        .load      (start_hit),
        .load_data (cfg_scan_data),
        .shift     (state == SHIFT),
        .sin       (bist_sdo),
        .capture   (shift_last && !abort_hit),
        .cap_clr   (start_hit),
        .sout      (bist_sdi),
        .cap_q     (sts_scan_out)
    );

    // Sequencing FSM with registered controls, counters and status capture.
    always_ff @(posedge bist_clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
            cfg_busy    <= 1'b0;
            cfg_done    <= 1'b0;
            sts_pass    <= 1'b0;
            sts_fail    <= 1'b0;
            sts_repair  <= 1'b0;
            sts_timeout <= 1'b0;
            sts_abort   <= 1'b0;
            sts_err_cnt <= '0;
            bist_en     <= 1'b0;
            bist_shift  <= 1'b0;
            bist_load   <= 1'b0;
            bist_run    <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            if (abort_hit) begin
                state      <= IDLE;
                cfg_busy   <= 1'b0;
                cfg_done   <= 1'b0 | 1'b1;
                sts_abort  <= 1'b1;
                bist_en    <= 1'b0;
                bist_shift <= 1'b0;
                bist_load  <= 1'b0;
                bist_run   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cfg_start) begin
                            state       <= SHIFT;
                            bit_cnt     <= '0;
                            tmo_cnt     <= cfg_tmo;
                            cfg_busy    <= 1'b1;
                            sts_pass    <= 1'b0;
                            sts_fail    <= 1'b0;
                            sts_repair  <= 1'b0;
                            sts_timeout <= 1'b0;
                            sts_abort   <= 1'b0;
                            sts_err_cnt <= '0;
                            bist_en     <= 1'b1;
                            bist_shift  <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (bit_cnt == BC_LAST) begin
                            state      <= LOAD;
                            bist_shift <= 1'b0;
                            bist_load  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    LOAD: begin
                        state     <= RUN;
                        bist_load <= 1'b0;
                        bist_run  <= 1'b1;
                    end
                    RUN: begin
                        if (bist_done) begin
                            state       <= STAT;
                            bist_run    <= 1'b0;
                            cfg_done    <= 1'b1;
                            sts_pass    <= !bist_error;
                            sts_fail    <= bist_error;
                            sts_repair  <= bist_correct;
                            sts_err_cnt <= bist_error_cnt;
                        end else if (tmo_cnt == TMO_ONE) begin
                            state       <= STAT;
                            bist_run    <= 1'b0;
                            cfg_done    <= 1'b1;
                            sts_timeout <= 1'b1;
                        end else if (tmo_cnt != '0) begin
                            tmo_cnt <= tmo_cnt - 1'b1;
                        end
                    end
                    STAT: begin
                        state    <= IDLE;
                        cfg_busy <= 1'b0;
                        bist_en  <= 1'b0;
                    end
                    default: begin
                        state      <= IDLE;
                        cfg_busy   <= 1'b0;
                        bist_en    <= 1'b0;
                        bist_shift <= 1'b0;
                        bist_load  <= 1'b0;
                        bist_run   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mbist_scan_seq.sv
// Bench for mbist_scan_seq with an 8-bit loopback scan chain model and a
// behavioural MBIST that raises bist_done after a programmed run length.
module tb_mbist_scan_seq;

    localparam int SW = 8;
    localparam int TW = 20;

    logic          bist_clk = 1'b0;
    logic          rst_n;
    logic          cfg_start;
    logic          cfg_abort;
    logic [SW-1:0] cfg_scan_data;
    logic [TW-1:0] cfg_tmo;
    logic          cfg_busy;
    logic          cfg_done;
    logic          sts_pass;
    logic          sts_fail;
    logic          sts_repair;
    logic          sts_timeout;
    logic          sts_abort;
    logic [3:0]    sts_err_cnt;
    logic [SW-1:0] sts_scan_out;
    logic          bist_en;
    logic          bist_shift;
    logic          bist_load;
    logic          bist_run;
    logic          bist_sdi;
    logic          bist_done;
    logic          bist_error;
    logic          bist_correct;
    logic          bist_sdo;
    logic [3:0]    bist_error_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural MBIST state.
    logic [SW-1:0] chain = 8'h3C;
    int            m_done_after = 0;
    int            m_run_cnt = 0;

    always #5 bist_clk = ~bist_clk;

    mbist_scan_seq #(
        .SCAN_WD (SW),
        .TMO_WD  (TW)
    ) dut (
        .bist_clk       (bist_clk),
        .rst_n          (rst_n),
        .cfg_start      (cfg_start),
        .cfg_abort      (cfg_abort),
        .cfg_scan_data  (cfg_scan_data),
        .cfg_tmo        (cfg_tmo),
        .cfg_busy       (cfg_busy),
        .cfg_done       (cfg_done),
        .sts_pass       (sts_pass),
        .sts_fail       (sts_fail),
        .sts_repair     (sts_repair),
        .sts_timeout    (sts_timeout),
        .sts_abort      (sts_abort),
        .sts_err_cnt    (sts_err_cnt),
        .sts_scan_out   (sts_scan_out),
        .bist_en        (bist_en),
        .bist_shift     (bist_shift),
        .bist_load      (bist_load),
        .bist_run       (bist_run),
        .bist_sdi       (bist_sdi),
        .bist_done      (bist_done),
        .bist_error     (bist_error),
        .bist_correct   (bist_correct),
        .bist_sdo       (bist_sdo),
        .bist_error_cnt (bist_error_cnt)
    );

    // Loopback chain: 8-deep delay from bist_sdi to bist_sdo while shifting.
    always @(posedge bist_clk) begin
        if (bist_shift) chain <= {bist_sdi, chain[SW-1:1]};
    end
    assign bist_sdo = chain[0];

    // Done model: raise bist_done during the programmed run cycle (0 = never).
    always @(negedge bist_clk) begin
        if (bist_run) begin
            m_run_cnt <= m_run_cnt + 1;
            bist_done <= (m_done_after != 0) && (m_run_cnt + 1 == m_done_after);
        end else begin
            m_run_cnt <= 0;
            bist_done <= 1'b0;
        end
    end

    typedef struct {
        logic [SW-1:0] data;
        logic [TW-1:0] tmo;
        int            done_after;
        logic          err;
        logic          corr;
        logic [3:0]    cnt;
        int            run_exp;
        logic          pass_exp;
        logic          fail_exp;
        logic          rep_exp;
        logic          tmo_exp;
        logic [3:0]    cnt_exp;
        logic [SW-1:0] scan_exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] all_out();
        return {cfg_busy, cfg_done, sts_pass, sts_fail, sts_repair, sts_timeout,
                sts_abort, sts_err_cnt, sts_scan_out,
                bist_en, bist_shift, bist_load, bist_run, bist_sdi};
    endfunction

    // Called at a negedge; returns at the negedge of the first cycle after the start edge.
    task automatic start_seq(input logic [SW-1:0] d, input logic [TW-1:0] t);
        cfg_scan_data = d;
        cfg_tmo       = t;
        cfg_start     = 1'b1;
        @(negedge bist_clk);
        cfg_start     = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int            cyc;
        int            shift_cnt, shift_last, load_cnt, load_cyc;
        int            run_cnt, run_first, done_cnt, done_cyc, busy_cnt, en_cnt;
        logic [SW-1:0] sdi_w;
        logic          ended;
        shift_cnt = 0; shift_last = 0; load_cnt = 0; load_cyc = 0;
        run_cnt = 0; run_first = 0; done_cnt = 0; done_cyc = 0;
        busy_cnt = 0; en_cnt = 0; sdi_w = '0; ended = 1'b0;
        m_done_after   = v.done_after;
        bist_error     = v.err;
        bist_correct   = v.corr;
        bist_error_cnt = v.cnt;
        start_seq(v.data, v.tmo);
        cyc = 1;
        while (!ended && cyc <= 3000) begin
            if (bist_shift) begin
                if (shift_cnt < SW) sdi_w[shift_cnt] = bist_sdi;
                shift_cnt++;
                shift_last = cyc;
            end
            if (bist_load) begin load_cnt++; load_cyc = cyc; end
            if (bist_run) begin
                if (run_cnt == 0) run_first = cyc;
                run_cnt++;
            end
            if (cfg_done) begin done_cnt++; done_cyc = cyc; end
            if (bist_en) en_cnt++;
            if (cfg_busy) busy_cnt++;
            if (!cfg_busy) ended = 1'b1;
            else begin
                @(negedge bist_clk);
                cyc++;
            end
        end
        check($sformatf("v%0d_finished", idx), 32'(ended), 32'd1);
        check($sformatf("v%0d_sdi_word", idx), 32'(sdi_w), 32'(v.data));
        check($sformatf("v%0d_shift_cnt", idx), shift_cnt, SW);
        check($sformatf("v%0d_shift_last", idx), shift_last, SW);
        check($sformatf("v%0d_load_cnt", idx), load_cnt, 1);
        check($sformatf("v%0d_load_cyc", idx), load_cyc, SW + 1);
        check($sformatf("v%0d_run_first", idx), run_first, SW + 2);
        check($sformatf("v%0d_run_cnt", idx), run_cnt, v.run_exp);
        check($sformatf("v%0d_done_cnt", idx), done_cnt, 1);
        check($sformatf("v%0d_done_cyc", idx), done_cyc, SW + 2 + v.run_exp);
        check($sformatf("v%0d_busy_cnt", idx), busy_cnt, SW + 2 + v.run_exp);
        check($sformatf("v%0d_en_cnt", idx), en_cnt, SW + 2 + v.run_exp);
        check($sformatf("v%0d_pass", idx), 32'(sts_pass), 32'(v.pass_exp));
        check($sformatf("v%0d_fail", idx), 32'(sts_fail), 32'(v.fail_exp));
        check($sformatf("v%0d_repair", idx), 32'(sts_repair), 32'(v.rep_exp));
        check($sformatf("v%0d_timeout", idx), 32'(sts_timeout), 32'(v.tmo_exp));
        check($sformatf("v%0d_err_cnt", idx), 32'(sts_err_cnt), 32'(v.cnt_exp));
        check($sformatf("v%0d_scan_out", idx), 32'(sts_scan_out), 32'(v.scan_exp));
        check($sformatf("v%0d_abort", idx), 32'(sts_abort), 32'd0);
    endtask

    initial begin
        //             data    tmo     done  err   corr  cnt    run  pass  fail  rep   tmo   cnt    scan
        vecs[0] = '{8'hA5, 20'd100, 20,   1'b0, 1'b0, 4'd0,  20,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h3C};
        vecs[1] = '{8'h5A, 20'd100, 7,    1'b1, 1'b1, 4'd3,  7,   1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 8'hA5};
        vecs[2] = '{8'hC3, 20'd5,   0,    1'b1, 1'b1, 4'hF,  5,   1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 8'h5A};
        vecs[3] = '{8'h0F, 20'd0,   1000, 1'b0, 1'b1, 4'd0,  1000,1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 8'hC3};
        vecs[4] = '{8'h96, 20'd1,   0,    1'b0, 1'b0, 4'd0,  1,   1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 8'h0F};
        vecs[5] = '{8'h69, 20'd10,  10,   1'b1, 1'b0, 4'd9,  10,  1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 8'h96};
        vecs[6] = '{8'h42, 20'd50,  4,    1'b0, 1'b0, 4'd0,  4,   1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h81};

        rst_n = 1'b0;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        cfg_scan_data = '0;
        cfg_tmo = '0;
        bist_error = 1'b0;
        bist_correct = 1'b0;
        bist_error_cnt = '0;
        repeat (3) @(negedge bist_clk);
        check("reset_outputs", 32'(all_out()), 32'd0);
        rst_n = 1'b1;
        @(negedge bist_clk);
        check("idle_after_reset", 32'(all_out()), 32'd0);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Abort while bit 3 is on bist_sdi; chain 69 takes four zeros -> 06.
        m_done_after = 0;
        start_seq(8'hF0, 20'd100);
        repeat (3) @(negedge bist_clk);
        check("abort_shift_pre_shift", 32'(bist_shift), 32'd1);
        cfg_abort = 1'b1;
        @(negedge bist_clk);
        cfg_abort = 1'b0;
        check("abort_shift_bist", 32'({bist_en, bist_shift, bist_load, bist_run, bist_sdi}), 32'd0);
        check("abort_shift_sts", 32'(sts_abort), 32'd1);
        check("abort_shift_done", 32'(cfg_done), 32'd1);
        check("abort_shift_busy", 32'(cfg_busy), 32'd0);
        @(negedge bist_clk);
        check("abort_shift_done_pulse", 32'(cfg_done), 32'd0);

        // Start ignored during RUN, then abort in RUN.
        start_seq(8'h81, 20'd0);
        for (int i = 0; i < 50 && !bist_run; i++) @(negedge bist_clk);
        check("abort_run_reached", 32'(bist_run), 32'd1);
        check("abort_run_scan_out", 32'(sts_scan_out), 32'h06);
        repeat (2) @(negedge bist_clk);
        cfg_scan_data = 8'hFF;
        cfg_start = 1'b1;
        @(negedge bist_clk);
        cfg_start = 1'b0;
        check("busy_start_ignored", 32'({cfg_busy, bist_run, bist_shift, bist_load}), 32'b1100);
        @(negedge bist_clk);
        check("busy_start_still_run", 32'(bist_run), 32'd1);
        cfg_abort = 1'b1;
        @(negedge bist_clk);
        cfg_abort = 1'b0;
        check("abort_run_bist", 32'({bist_en, bist_shift, bist_load, bist_run, bist_sdi}), 32'd0);
        check("abort_run_sts", 32'({sts_abort, sts_pass, sts_fail, sts_timeout}), 32'b1000);
        check("abort_run_done", 32'(cfg_done), 32'd1);
        check("abort_run_busy", 32'(cfg_busy), 32'd0);
        @(negedge bist_clk);
        check("abort_run_no_requeue", 32'({cfg_busy, cfg_done, bist_shift}), 32'd0);
        check("abort_run_scan_hold", 32'(sts_scan_out), 32'h06);

        // Normal sequence after aborts.
        run_vec(6, vecs[6]);

        // Reset in the middle of SHIFT.
        start_seq(8'hFF, 20'd100);
        repeat (2) @(negedge bist_clk);
        check("rst_mid_pre_shift", 32'(bist_shift), 32'd1);
        rst_n = 1'b0;
        @(negedge bist_clk);
        check("rst_mid_outputs", 32'(all_out()), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge bist_clk);
        check("rst_mid_stays_idle", 32'({cfg_busy, bist_en}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
